// File: rtl/parity_frame_scheduler.sv
// Round-robin scheduler that shares one frame-parity engine among NREQ byte
// streams; each granted frame yields its parity, owner id and saturating byte count.
module parity_frame_scheduler #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0,
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_parity,
  output logic [ID_W-1:0]        res_id,
  output logic [7:0]             res_count,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] grant_id_q;
  logic            acc_q;
  logic [7:0]      cnt_q;
  logic [NREQ-1:0] req_ready_q;
  logic            res_valid_q;
  logic            res_parity_q;
  logic [7:0]      res_count_q;
  logic            busy_q;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [DATA_W-1:0] beat;
  logic            beat_ok;
  logic            acc_d;
  logic [7:0]      cnt_d;
  logic [ID_W-1:0] rr_ptr_d;

  // Rotating priority: scan upward from rr_ptr_q, first valid requester wins.
  always_comb begin
    int idx;
    // NOTE: every comb output gets a default before the loop so no path can infer a latch.
    win_found = 1'b0;
    win_id    = rr_ptr_q;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign beat     = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
  assign beat_ok  = req_valid[grant_id_q] & req_ready_q[grant_id_q];
  assign acc_d    = acc_q ^ (^beat);
  assign cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign rr_ptr_d = (grant_id_q == ID_W'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      acc_q        <= 1'b0;
      cnt_q        <= 8'd0;
      req_ready_q  <= '0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_count_q  <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_id_q  <= win_id;
            acc_q       <= 1'b0;
            cnt_q       <= 8'd0;
            req_ready_q <= NREQ'(1) << win_id;
            busy_q      <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (beat_ok) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (req_last[grant_id_q]) begin
              res_parity_q <= acc_d ^ ODD;
              res_count_q  <= cnt_d;
              req_ready_q  <= '0;
              res_valid_q  <= 1'b1;
              state_q      <= RESULT;
            end
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign res_valid  = res_valid_q;
  assign res_parity = res_parity_q;
  assign res_id     = grant_id_q;
  assign res_count  = res_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Bench for parity_frame_scheduler: frame-level reference model with per-cycle
// output comparison, directed literal scenarios and a randomized traffic phase.
module tb_parity_frame_scheduler;
  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic [NREQ-1:0]        req_last = '0;
  logic                   res_ready = 1'b0;

  logic [NREQ-1:0] req_ready, rdy_b;
  logic            res_valid, res_parity, busy, rv_b, par_b, busy_b;
  logic [ID_W-1:0] res_id, id_b;
  logic [7:0]      res_count, cnt_b;

  parity_frame_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W), .ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_parity(res_parity), .res_id(res_id),
    .res_count(res_count), .busy(busy));

  parity_frame_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy_b), .res_valid(rv_b),
    .res_ready(res_ready), .res_parity(par_b), .res_id(id_b),
    .res_count(cnt_b), .busy(busy_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Stimulus: per-requester queues of {last, data} beats.
  logic [8:0] beatq[NREQ][$];
  int valid_pct = 100;
  int ready_pct = 100;
  int hold_off  = 0;
  int cyc       = 0;
  bit fresh     = 1'b0;
  int valid_rise_cyc[NREQ];
  int ready_rise_cyc[NREQ];

  // Reference model: frame-level view of who owns the engine.
  typedef enum {M_IDLE, M_XFER, M_REPORT} mphase_t;
  mphase_t    m_phase = M_IDLE;
  int         m_owner = 0;
  int         m_ptr   = 0;
  int         m_par   = 0;
  int         m_cnt   = 0;
  logic [7:0] m_frame[$];

  typedef struct {int id; int par; int par_odd; int cnt; int rise_cyc;} res_t;
  res_t got_log[$];
  res_t last_seen;
  logic [NREQ-1:0] prev_rdy = '0;
  logic prev_rv = 1'b0;

  task automatic push_byte(input int k, input logic [7:0] d, input logic last);
    beatq[k].push_back({last, d});
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_owner = 0; m_ptr = 0; m_par = 0; m_cnt = 0;
    m_frame.delete();
    prev_rdy = '0; prev_rv = 1'b0;
  endtask

  task automatic model_step();
    int k;
    int ones;
    case (m_phase)
      M_IDLE: begin
        for (int d = 0; d < NREQ; d++) begin
          k = (m_ptr + d) % NREQ;
          if (req_valid[k]) begin
            m_owner = k;
            m_frame.delete();
            m_phase = M_XFER;
            break;
          end
        end
      end
      M_XFER: begin
        if (req_valid[m_owner]) begin
          m_frame.push_back(req_data[m_owner*DATA_W +: DATA_W]);
          void'(beatq[m_owner].pop_front());
          if (req_last[m_owner]) begin
            ones = 0;
            foreach (m_frame[i]) ones += $countones(m_frame[i]);
            m_par   = ones % 2;
            m_cnt   = (m_frame.size() > 255) ? 255 : m_frame.size();
            m_phase = M_REPORT;
          end
        end
      end
      M_REPORT: begin
        if (res_ready) begin
          got_log.push_back(last_seen);
          m_ptr   = (m_owner + 1) % NREQ;
          m_phase = M_IDLE;
        end
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic compare();
    logic [NREQ-1:0] exp_rdy;
    exp_rdy = (m_phase == M_XFER) ? (NREQ'(1) << m_owner) : '0;
    check("req_ready", int'(req_ready), int'(exp_rdy));
    check("res_valid", int'(res_valid), int'(m_phase == M_REPORT));
    check("busy", int'(busy), int'(m_phase != M_IDLE));
    check("odd_req_ready", int'(rdy_b), int'(exp_rdy));
    check("odd_res_valid", int'(rv_b), int'(m_phase == M_REPORT));
    if (m_phase == M_REPORT) begin
      check("res_id", int'(res_id), m_owner);
      check("res_parity", int'(res_parity), m_par);
      check("res_count", int'(res_count), m_cnt);
      check("odd_res_parity", int'(par_b), m_par ^ 1);
    end
    for (int k = 0; k < NREQ; k++)
      if (req_ready[k] && !prev_rdy[k]) ready_rise_cyc[k] = cyc;
    if (res_valid) begin
      if (!prev_rv) last_seen.rise_cyc = cyc;
      last_seen.id = int'(res_id); last_seen.par = int'(res_parity);
      last_seen.par_odd = int'(par_b); last_seen.cnt = int'(res_count);
    end
    prev_rdy = req_ready;
    prev_rv  = res_valid;
  endtask

  task automatic drive_inputs();
    logic [NREQ-1:0] v;
    v = '0;
    for (int k = 0; k < NREQ; k++) begin
      v[k] = (beatq[k].size() > 0) && (hold_off == 0) && ($urandom_range(99) < valid_pct);
      if (v[k]) begin
        req_data[k*DATA_W +: DATA_W] = beatq[k][0][7:0];
        req_last[k] = beatq[k][0][8];
        if (!req_valid[k]) valid_rise_cyc[k] = cyc;
      end else begin
        req_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        req_last[k] = 1'($urandom);
      end
    end
    if (hold_off > 0) hold_off--;
    req_valid = v;
    res_ready = ($urandom_range(99) < ready_pct);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (fresh) fresh = 1'b0;
      else model_step();
      compare();
      drive_inputs();
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_parity"}, int'(res_parity), 0);
    check({tag, "_res_id"}, int'(res_id), 0);
    check({tag, "_res_count"}, int'(res_count), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_odd_res_valid"}, int'(rv_b), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; res_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) beatq[k].delete();
    hold_off = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    fresh = 1'b1;
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NREQ; k++) if (beatq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !(all_empty() && m_phase == M_IDLE)) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_drain_timeout"}, int'(n < budget), 1);
  endtask

  initial begin
    int n;
    do_reset();

    // Single byte 0x07 from requester 2: parity 1 (odd instance 0), one-cycle grant.
    got_log.delete();
    push_byte(2, 8'h07, 1'b1);
    wait_drain("t1", 50);
    check("t1_results", got_log.size(), 1);
    if (got_log.size() == 1) begin
      check("t1_id", got_log[0].id, 2);
      check("t1_parity", got_log[0].par, 1);
      check("t1_parity_odd", got_log[0].par_odd, 0);
      check("t1_count", got_log[0].cnt, 1);
      check("t1_grant_latency", ready_rise_cyc[2] - valid_rise_cyc[2], 1);
      check("t1_result_latency", got_log[0].rise_cyc - valid_rise_cyc[2], 2);
    end

    // Three-beat frame 0xFF, 0x01, 0x80: ten ones, even.
    got_log.delete();
    push_byte(0, 8'hFF, 1'b0); push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h80, 1'b1);
    wait_drain("t2", 50);
    check("t2_results", got_log.size(), 1);
    if (got_log.size() == 1) begin
      check("t2_id", got_log[0].id, 0);
      check("t2_parity", got_log[0].par, 0);
      check("t2_count", got_log[0].cnt, 3);
    end

    // Everyone requesting continuously: strict rotation from index 0.
    do_reset();
    got_log.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NREQ; k++) push_byte(k, 8'($urandom), 1'b1);
    wait_drain("t3", 200);
    check("t3_results", got_log.size(), 2 * NREQ);
    foreach (got_log[i]) check("t3_rotation", got_log[i].id, i % NREQ);

    // Result backpressure: outputs hold, no new grant while requester 3 waits.
    got_log.delete();
    ready_pct = 0;
    push_byte(1, 8'h3C, 1'b1);
    push_byte(3, 8'h5A, 1'b1);
    n = 0;
    while (n < 50 && !res_valid) begin @(negedge clk); #1; n++; end
    check("t4_result_timeout", int'(n < 50), 1);
    repeat (5) begin
      @(negedge clk); #1;
      check("t4_hold_valid", int'(res_valid), 1);
      check("t4_hold_id", int'(res_id), 1);
      check("t4_hold_parity", int'(res_parity), 0);
      check("t4_hold_count", int'(res_count), 1);
      check("t4_no_grant", int'(req_ready), 0);
    end
    ready_pct = 100;
    wait_drain("t4", 50);
    check("t4_results", got_log.size(), 2);
    if (got_log.size() == 2) begin
      check("t4_first_id", got_log[0].id, 1);
      check("t4_second_id", got_log[1].id, 3);
    end

    // Valid gap mid-frame: 0x01, 0x02, 0x07 -> five ones, odd.
    got_log.delete();
    push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b0); push_byte(0, 8'h07, 1'b1);
    n = 0;
    while (n < 50 && beatq[0].size() != 2) begin @(negedge clk); #1; n++; end
    check("t5_first_beat_timeout", int'(n < 50), 1);
    hold_off = 3;
    wait_drain("t5", 50);
    check("t5_results", got_log.size(), 1);
    if (got_log.size() == 1) begin
      check("t5_parity", got_log[0].par, 1);
      check("t5_count", got_log[0].cnt, 3);
    end

    // 300 beats of 0x01: count saturates, parity over all beats is even.
    got_log.delete();
    for (int i = 0; i < 300; i++) push_byte(3, 8'h01, i == 299);
    wait_drain("t6", 400);
    check("t6_results", got_log.size(), 1);
    if (got_log.size() == 1) begin
      check("t6_count", got_log[0].cnt, 255);
      check("t6_parity", got_log[0].par, 0);
    end

    // Move the pointer off zero, then reset during the second beat of a frame.
    push_byte(1, 8'h11, 1'b1);
    wait_drain("t7_pre", 50);
    got_log.delete();
    for (int i = 0; i < 4; i++) push_byte(2, 8'(i + 1), i == 3);
    n = 0;
    while (n < 50 && beatq[2].size() != 3) begin @(negedge clk); #1; n++; end
    check("t7_first_beat_timeout", int'(n < 50), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7_async");
    do_reset();
    push_byte(0, 8'h01, 1'b1);
    push_byte(3, 8'h03, 1'b1);
    wait_drain("t7", 50);
    check("t7_results", got_log.size(), 2);
    if (got_log.size() == 2) begin
      check("t7_first_id", got_log[0].id, 0);
      check("t7_second_id", got_log[1].id, 3);
    end

    // Randomized traffic with valid gaps and result backpressure.
    got_log.delete();
    valid_pct = 70;
    ready_pct = 60;
    for (int k = 0; k < NREQ; k++)
      for (int f = 0; f < 5; f++) begin
        n = $urandom_range(1, 5);
        for (int b = 0; b < n; b++) push_byte(k, 8'($urandom), b == n - 1);
      end
    wait_drain("rand", 5000);
    check("rand_results", got_log.size(), 5 * NREQ);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
